seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits (WIDTH >= 4).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled on rising edge, accepted only when idle.
REQ-005 SHALL have port numer  input  WIDTH  signed dividend; sampled on accepting edge only.
REQ-006 SHALL have port denom  input  WIDTH  signed divisor; sampled on accepting edge only.
REQ-007 SHALL have port busy  output  1  high while an operation is in flight.
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid and updated.
REQ-009 SHALL have port quotient  output  WIDTH  signed quotient, registered.
REQ-010 SHALL have port remain  output  WIDTH  signed remainder, registered.
REQ-011 SHALL have port divzero  output  1  registered flag; last completed op had denom == 0.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, FIX.
REQ-013 SHALL, in IDLE with start=1 at edge E0: latch |numer|, |denom|, both operand signs and the denom==0 flag; load iteration counter with WIDTH; go to RUN.
REQ-014 SHALL perform one radix-2 restoring step per RUN edge on the unsigned magnitudes (shift remainder/quotient left, trial subtract, keep on non-negative); go to FIX after the WIDTH-th step (edge E0+WIDTH).
REQ-015 SHALL, at edge E0+WIDTH+1 in FIX, write quotient/remain/divzero, assert done, go to IDLE.
REQ-016 SHALL drive done high for exactly one cycle (between edges E0+WIDTH+1 and E0+WIDTH+2).
REQ-017 SHALL drive busy high from edge E0 to edge E0+WIDTH+1 (states RUN and FIX), low in IDLE.
REQ-018 SHALL truncate toward zero: quotient negative iff operand signs differ; remainder takes the sign of numer; numer == quotient*denom + remain.
REQ-019 SHALL handle magnitude of the most negative value (-2^(WIDTH-1)) as unsigned 2^(WIDTH-1) without overflow internally.
REQ-020 SHALL, for -2^(WIDTH-1) / -1, return quotient = -2^(WIDTH-1) (wrapped) and remain = 0, divzero = 0.
REQ-021 SHALL, for denom == 0, keep full latency and return quotient = all ones, remain = numer, divzero = 1.
REQ-022 SHALL ignore start while busy; in-flight operands and results remain unaffected.
REQ-023 SHALL accept start in the cycle done is high (state IDLE), allowing back-to-back ops every WIDTH+2 cycles.
REQ-024 SHALL hold quotient, remain, divzero stable between done pulses.
REQ-025 SHALL not depend on numer/denom values outside the accepting edge.

Reset
REQ-026 SHALL, on resetn low, immediately force state IDLE, busy 0, done 0, quotient 0, remain 0, divzero 0, counter 0.
REQ-027 SHALL abort any in-flight operation on reset with no done pulse afterwards.
REQ-028 SHALL ignore start on any edge where resetn is low; first acceptance on first edge with resetn high.

Verification (WIDTH=16)
REQ-029 SHALL cover signs: 100/7 -> 14,2; -100/7 -> -14,-2; 100/-7 -> -14,2; -100/-7 -> 14,-2; done exactly 17 edges after accept.
REQ-030 SHALL cover edges: -32768/-1 -> quotient 0x8000, remain 0; -32768/1 -> 0x8000, 0; 32767/32767 -> 1, 0; 3/5 -> 0, 3.
REQ-031 SHALL cover divide by zero: 5/0 -> quotient 0xFFFF, remain 5, divzero 1; next 9/3 -> 3, 0, divzero 0.
REQ-032 SHALL cover handshake: start held high continuously -> one done every 18 cycles; start pulse mid-RUN with other operands -> ignored, results unchanged.
REQ-033 SHALL cover reset: resetn low at edge E0+8 -> busy/done/outputs 0 at once, no later done; new op after release completes normally.
REQ-034 SHALL cover random signed operands (>=10000, incl. 0 and extremes) against truncating reference model.

Source files
------------

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider: operands and start go in; busy, done and results come out.
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] numer;
  logic [WIDTH-1:0] denom;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remain;
  logic             divzero;

  modport master (
    output start, numer, denom,
    input  busy, done, quotient, remain, divzero
  );

  modport slave (
    input  start, numer, denom,
    output busy, done, quotient, remain, divzero
  );
endinterface

// File: rtl/seq_divider.sv
// Signed sequential divider: radix-2 restoring division on magnitudes, one bit per cycle,
// truncating toward zero, with a sign-fixup cycle before results are published.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic         clock,
  input  logic         resetn,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic             num_neg_q, num_neg_d;
  logic             den_neg_q, den_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remain_q, remain_d;
  logic             divzero_q, divzero_d;
  logic             done_q, done_d;

  // One extra bit so the trial subtraction's borrow is visible; magnitudes of
  // -2^(WIDTH-1) are held as unsigned 2^(WIDTH-1), which still fits in WIDTH bits.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  assign trial = {rem_q, acc_q[WIDTH-1]};
  assign diff  = trial - {1'b0, den_q};

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    acc_d      = acc_q;
    den_d      = den_q;
    num_neg_d  = num_neg_q;
    den_neg_d  = den_neg_q;
    dz_d       = dz_q;
    quotient_d = quotient_q;
    remain_d   = remain_q;
    divzero_d  = divzero_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          num_neg_d = bus.numer[WIDTH-1];
          den_neg_d = bus.denom[WIDTH-1];
          acc_d     = bus.numer[WIDTH-1] ? -bus.numer : bus.numer;
          den_d     = bus.denom[WIDTH-1] ? -bus.denom : bus.denom;
          dz_d      = (bus.denom == '0);
          rem_d     = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = RUN;
        end
      end

      RUN: begin
        // Keep the subtraction only when it did not borrow; the quotient bit
        // shifts into the vacated low end of the dividend register.
        rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        acc_d = {acc_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end

      FIX: begin
        // With a zero divisor the remainder register ends up holding |numer|,
        // so the normal sign fixup already returns numer itself.
        if (dz_q)                       quotient_d = '1;
        else if (num_neg_q ^ den_neg_q) quotient_d = -acc_q;
        else                            quotient_d = acc_q;
        remain_d  = num_neg_q ? -rem_q : rem_q;
        divzero_d = dz_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      den_q      <= '0;
      num_neg_q  <= 1'b0;
      den_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      quotient_q <= '0;
      remain_q   <= '0;
      divzero_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      acc_q      <= acc_d;
      den_q      <= den_d;
      num_neg_q  <= num_neg_d;
      den_neg_q  <= den_neg_d;
      dz_q       <= dz_d;
      quotient_q <= quotient_d;
      remain_q   <= remain_d;
      divzero_q  <= divzero_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.quotient = quotient_q;
  assign bus.remain   = remain_q;
  assign bus.divzero  = divzero_q;

endmodule
